// File: rtl/ereg_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ereg_hazard_ctrl
// Purpose  : Y86-64 decode-to-execute (E) pipeline register with the
//            pipeline hazard controller for the F and D registers, a sticky
//            halt flag and saturating stall/bubble event counters.
// Revision : 1.0 - initial release
// ============================================================================
module ereg_hazard_ctrl #(
   parameter int         CNT_W = 32,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic             clk,
   input  logic             rst,
   // decode-stage results
   input  logic [1:0]       d_stat,
   input  logic [3:0]       d_icode,
   input  logic [3:0]       d_ifun,
   input  logic [63:0]      d_valC,
   input  logic [63:0]      d_valA,
   input  logic [63:0]      d_valB,
   input  logic [3:0]       d_dstE,
   input  logic [3:0]       d_dstM,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   // other pipeline context
   input  logic [3:0]       D_icode,
   input  logic [3:0]       M_icode,
   input  logic             e_Cnd,
   input  logic [1:0]       W_stat,
   // E register state
   output logic [1:0]       E_stat,
   output logic [3:0]       E_icode,
   output logic [3:0]       E_ifun,
   output logic [63:0]      E_valC,
   output logic [63:0]      E_valA,
   output logic [63:0]      E_valB,
   output logic [3:0]       E_dstE,
   output logic [3:0]       E_dstM,
   output logic [3:0]       E_srcA,
   output logic [3:0]       E_srcB,
   // pipeline control
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   // status and performance debug
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   // Instruction codes referenced by the hazard logic
   localparam logic [3:0] C_NOP    = 4'h1;
   localparam logic [3:0] C_MRMOVQ = 4'h5;
   localparam logic [3:0] C_JXX    = 4'h7;
   localparam logic [3:0] C_RET    = 4'h9;
   localparam logic [3:0] C_POPQ   = 4'hB;

   localparam logic [1:0] C_STAT_AOK = 2'd0;
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic load_use;
   logic mispred;
   logic ret_in;
   logic e_is_load;
   logic stall_sat;
   logic bubble_sat;

   // Raw hazard detection on the current-cycle pipeline contents
   always_comb begin
      e_is_load = (E_icode == C_MRMOVQ) || (E_icode == C_POPQ);
      load_use  = e_is_load && (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      mispred   = (E_icode == C_JXX) && !e_Cnd;
      ret_in    = (D_icode == C_RET) || (E_icode == C_RET) || (M_icode == C_RET);
   end

   // Stall/bubble controls; a halted pipeline freezes so all controls drop.
   // On load_use + mispred both D_stall and D_bubble are raised and the D
   // register resolves stall-over-bubble itself.
   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      if (!halted) begin
         F_stall  = load_use || ret_in;
         D_stall  = load_use;
         D_bubble = mispred || (ret_in && !load_use);
         E_bubble = mispred || load_use;
      end
   end

   // E register: hold when halted, otherwise bubble or capture decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         E_stat  <= C_STAT_AOK;
         E_icode <= C_NOP;
         E_ifun  <= 4'h0;
         E_valC  <= 64'd0;
         E_valA  <= 64'd0;
         E_valB  <= 64'd0;
         E_dstE  <= RNONE;
         E_dstM  <= RNONE;
         E_srcA  <= RNONE;
         E_srcB  <= RNONE;
      end else if (halted) begin
         E_stat  <= E_stat;
         E_icode <= E_icode;
         E_ifun  <= E_ifun;
         E_valC  <= E_valC;
         E_valA  <= E_valA;
         E_valB  <= E_valB;
         E_dstE  <= E_dstE;
         E_dstM  <= E_dstM;
         E_srcA  <= E_srcA;
         E_srcB  <= E_srcB;
      end else if (E_bubble) begin
         E_stat  <= C_STAT_AOK;
         E_icode <= C_NOP;
         E_ifun  <= 4'h0;
         E_valC  <= 64'd0;
         E_valA  <= 64'd0;
         E_valB  <= 64'd0;
         E_dstE  <= RNONE;
         E_dstM  <= RNONE;
         E_srcA  <= RNONE;
         E_srcB  <= RNONE;
      end else begin
         E_stat  <= d_stat;
         E_icode <= d_icode;
         E_ifun  <= d_ifun;
         E_valC  <= d_valC;
         E_valA  <= d_valA;
         E_valB  <= d_valB;
         E_dstE  <= d_dstE;
         E_dstM  <= d_dstM;
         E_srcA  <= d_srcA;
         E_srcB  <= d_srcB;
      end
   end

   // Sticky halt: set when a non-AOK status reaches writeback
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted <= 1'b0;
      end else if (W_stat != C_STAT_AOK) begin
         halted <= 1'b1;
      end
   end

   // Saturation flags keep the counters pinned at all-ones
   always_comb begin
      stall_sat  = (stall_cnt  == C_CNT_MAX);
      bubble_sat = (bubble_cnt == C_CNT_MAX);
   end

   // Stall event counter (cycles with F_stall); frozen while halted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (F_stall && !stall_sat) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // Bubble event counter (cycles with E_bubble, once per cycle)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (E_bubble && !bubble_sat) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/ereg_hazard_ctrl.md
Name: ereg_hazard_ctrl

Overview:
- Decode-to-execute pipeline register (the E register) with integrated Y86-64 pipeline hazard control.
- Captures decode-stage results (d_*) into the E_* state that feeds the execute stage.
- Generates the stall and bubble controls for the F and D registers.
- Counts stall and bubble events for performance debug.

Parameters:
CNT_W, 32, width of the stall and bubble event counters
RNONE, 4'hF, register ID meaning "no register"

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
d_stat  input  2  decode status (0 AOK, 1 HLT, 2 ADR, 3 INS)
d_icode, d_ifun  input  4 each  decoded instruction code and function
d_valC, d_valA, d_valB  input  64 each  decode-stage operand values
d_dstE, d_dstM, d_srcA, d_srcB  input  4 each  decode-stage register IDs
D_icode  input  4  icode currently in the D register
M_icode  input  4  icode currently in the M register
e_Cnd  input  1  branch condition computed by execute this cycle
W_stat  input  2  writeback status
E_stat  output  2  E register status
E_icode, E_ifun  output  4 each  E register instruction code and function
E_valC, E_valA, E_valB  output  64 each  E register operand values
E_dstE, E_dstM, E_srcA, E_srcB  output  4 each  E register register IDs
F_stall  output  1  hold the F register
D_stall  output  1  hold the D register
D_bubble  output  1  load a nop into the D register
E_bubble  output  1  internal E-bubble decision, exported for debug
halted  output  1  sticky halt flag
stall_cnt  output  CNT_W  saturating count of cycles with F_stall=1
bubble_cnt  output  CNT_W  saturating count of cycles with E_bubble=1

Behaviour:
Icode encoding:
- HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.

Reset (asynchronous):
- While rst=1, the E register holds the bubble value: stat=0, icode=1, ifun=0, valC/valA/valB=0, all four register IDs=RNONE.
- Reset clears halted, stall_cnt and bubble_cnt.
- Asserting rst mid-operation clears all state immediately, without waiting for a clock edge.

Hazard terms (combinational, all on current-cycle values):
- load_use = (E_icode==MRMOVQ or E_icode==POPQ) and E_dstM!=RNONE and (E_dstM==d_srcA or E_dstM==d_srcB).
- mispred = (E_icode==JXX) and !e_Cnd.
- ret_in = RET present in any of D_icode, E_icode, M_icode.

Control outputs:
- F_stall = load_use or ret_in.
- D_stall = load_use.
- D_bubble = mispred or (ret_in and !load_use).
- E_bubble = mispred or load_use.
- When halted=1, all four control outputs are forced to 0.

E register update at each clock edge, in priority order:
1. halted=1: hold all E values.
2. E_bubble=1: load the bubble value.
3. Otherwise: load the d_* inputs.
- The E register never stalls.
- Latency: d_* appear on E_* exactly 1 cycle after capture.

Halt:
- halted is set at the clock edge where W_stat!=0, and stays set until reset.
- The E register hold takes effect from the following edge.

Counters:
- Each counter increments by 1 per qualifying cycle.
- Each counter saturates at all-ones and never wraps.
- Counters do not increment while halted=1.

Simultaneous events:
- mispred and load_use together give E_bubble=1 and D_stall=1, with D_bubble=1 also asserted.
- The D-register logic gives stall priority over bubble in that case.
- bubble_cnt increments once per such cycle, not twice.

Outputs are registered except F_stall, D_stall, D_bubble and E_bubble, which are combinational.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with E_icode=6 -> E_icode=1 and E_dstE=F immediately; halted=0; both counters 0.
- Pass-through: d_icode=3, d_valC=64'h1234, d_dstE=2, all other terms idle -> next edge E_icode=3, E_valC=64'h1234, E_dstE=2; all stall/bubble outputs 0.
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; next edge E_icode=1; stall_cnt=1, bubble_cnt=1.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; next edge E holds the nop value.
- Return: D_icode=9 held for 3 cycles -> F_stall=1 and D_bubble=1 on each cycle; stall_cnt=3; E loads d_* normally.
- Halt and saturation: W_stat=1 -> halted=1 at that edge; from the next edge E_* hold and all control outputs are 0. Separately, preload counters near saturation (CNT_W=4 build) and apply 20 load_use cycles -> stall_cnt=4'hF, no wrap.
